// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, FSM encoding, round-key slicing, GF(2^8) helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package aes_pkg;
  localparam int AES_NB  = 4;
  localparam int AES_BLK = 128;
  // Widest expanded key (AES-256, 15 round keys); narrower keys are zero-extended.
  localparam int AES_EXP_MAX = AES_BLK * 15;

  typedef enum logic [1:0] {
    DEC_IDLE  = 2'd0,
    DEC_ROUND = 2'd1,
    DEC_FINAL = 2'd2,
    DEC_DONE  = 2'd3
  } dec_state_e;

  // InvMixColumns row coefficients; row r uses them rotated right by r.
  localparam logic [7:0] IMC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic bit dec_params_ok(input int nk, input int nr, input int nb);
    return (nk == 4 || nk == 6 || nk == 8) && (nr == nk + 6) && (nb == AES_NB);
  endfunction

  // Round 0 sits in the MSBs, round nr in the LSBs.
  function automatic logic [AES_BLK-1:0] round_key(input logic [AES_EXP_MAX-1:0] ek,
                                                   input int nr, input int r);
    return ek[AES_BLK*(nr+1-r)-1 -: AES_BLK];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse S-box as inverse affine map followed by x^254 (the field inverse, 0 -> 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a, x2, x3, x12, x15, x240, x252;
    a    = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction
endpackage

// File: rtl/AddRoundKey.sv
// Round-key addition: state XOR key.
// Latency: combinational.  Ports: state_in, key, state_out (128 bits each).
// Backpressure: n/a.
module AddRoundKey (
  input  logic [127:0] state_in,
  input  logic [127:0] key,
  output logic [127:0] state_out
);
  assign state_out = state_in ^ key;
endmodule

// File: rtl/aes_inv_last_round.sv
// Last inverse round (no InvMixColumns): InvShiftRows, InvSubBytes, AddRoundKey with key(0).
// Latency: combinational.  Ports: state_in, key, state_out.
// Backpressure: n/a.
module aes_inv_last_round (
  input  logic [127:0] state_in,
  input  logic [127:0] key,
  output logic [127:0] state_out
);
  logic [127:0] shifted, subbed;

  inv_shiftrow127 u_shift (.state_in(state_in), .state_out(shifted));
  inverse_subByte u_sub   (.state_in(shifted),  .state_out(subbed));
  AddRoundKey     u_ark   (.state_in(subbed), .key(key), .state_out(state_out));
endmodule

// File: rtl/decryptRound.sv
// One middle inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Latency: combinational.  Ports: state_in, key, state_out.
// Backpressure: n/a.
module decryptRound
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] key,
  output logic [127:0] state_out
);
  logic [127:0] shifted, subbed, keyed;
  logic [7:0]   acc;

  inv_shiftrow127 u_shift (.state_in(state_in), .state_out(shifted));
  inverse_subByte u_sub   (.state_in(shifted),  .state_out(subbed));
  AddRoundKey     u_ark   (.state_in(subbed), .key(key), .state_out(keyed));

  always_comb begin
    state_out = '0;
    acc       = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gf_mul(IMC_COEF[(k-r+4)%4], keyed[127-8*(4*c+k) -: 8]);
        end
        state_out[127-8*(4*c+r) -: 8] = acc;
      end
    end
  end
endmodule

// File: rtl/inv_shiftrow127.sv
// InvShiftRows on a 128-bit state, byte 0 in the MSBs, column-major (byte 4c+r).
// Latency: combinational.  Ports: state_in, state_out.
// Backpressure: n/a.
module inv_shiftrow127 (
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        // Row r rotates right by r columns.
        state_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end
endmodule

// File: rtl/inverse_subByte.sv
// InvSubBytes on all 16 state bytes.
// Latency: combinational.  Ports: state_in, state_out.
// Backpressure: n/a.
module inverse_subByte
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = inv_sbox(state_in[127-8*i -: 8]);
    end
  end
endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher, one round per clock; in_* ciphertext, out_* plaintext, exp_key unlatched.
// Latency: Nr+1 cycles accept-to-valid; initiation interval Nr+2 (one DONE + one IDLE cycle).
// Backpressure: single block in flight; in_ready only in IDLE, result held in DONE until out_ready.
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int Nk = 6,
  parameter int Nr = 12,
  parameter int Nb = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [128*(Nr+1)-1:0]  exp_key,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_data,
  output logic                   busy,
  output logic [7:0]             dbg_byte
);
  localparam int CW = $clog2(Nr + 1);

  if (!dec_params_ok(Nk, Nr, Nb)) begin : g_bad_params
    $error("aes_decrypt_core: need Nk in {4,6,8}, Nr == Nk+6, Nb == 4");
  end

  dec_state_e          fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [127:0]        out_data_q, out_data_d;
  logic [CW-1:0]       round_ctr_q, round_ctr_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [7:0]          dbg_byte_q, dbg_byte_d;

  logic [AES_EXP_MAX-1:0] key_ext;
  logic [127:0]           key_first, key_mid, key_last;
  logic [127:0]           round_out, last_out;

  assign key_ext   = AES_EXP_MAX'(exp_key);
  assign key_last  = round_key(key_ext, Nr, Nr);
  assign key_mid   = round_key(key_ext, Nr, int'(round_ctr_q));  // (Nr+1):1 mux on round_ctr
  assign key_first = round_key(key_ext, Nr, 0);

  decryptRound       u_round (.state_in(state_q), .key(key_mid),   .state_out(round_out));
  aes_inv_last_round u_last  (.state_in(state_q), .key(key_first), .state_out(last_out));

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (fsm_q)
      DEC_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d     = in_data ^ key_last;
          round_ctr_d = CW'(Nr - 1);
          fsm_d       = DEC_ROUND;
        end
      end
      DEC_ROUND: begin
        state_d     = round_out;
        round_ctr_d = round_ctr_q - CW'(1);
        // Leaving at 1 gives exactly Nr-1 middle rounds and keeps the counter from wrapping.
        if (round_ctr_q == CW'(1)) fsm_d = DEC_FINAL;
      end
      DEC_FINAL: begin
        out_data_d  = last_out;
        out_valid_d = 1'b1;
        fsm_d       = DEC_DONE;
      end
      DEC_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = DEC_IDLE;
        end
      end
      default: fsm_d = DEC_IDLE;
    endcase
    // Registered decodes of the next state keep these outputs glitch-free.
    in_ready_d = (fsm_d == DEC_IDLE);
    busy_d     = (fsm_d != DEC_IDLE);
    dbg_byte_d = (fsm_d == DEC_DONE) ? out_data_d[7:0] : state_d[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= DEC_IDLE;
      state_q     <= '0;
      round_ctr_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      dbg_byte_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      dbg_byte_q  <= dbg_byte_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign dbg_byte  = dbg_byte_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core at AES-128/192/256: plaintexts are encrypted by a forward-cipher model,
// the ciphertext is fed in, and a per-instance monitor checks plaintext, latency and hold behaviour.
module tb_aes_decrypt_core;
  localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] FIPS_CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0]        sbox [256];
  logic [128*15-1:0] ek   [3];
  logic              iv [3], irdy [3], ov [3], ordy [3], bsy [3];
  logic [127:0]      idat [3], od [3];
  logic [7:0]        dbg [3];
  logic [127:0]      exp_q   [3][$];
  int                stamp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Forward S-box from the generator 3 and its inverse walk, then the affine map.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // KeyExpansion; key words taken from the MSBs of 'key'. Round 0 lands in the MSBs.
  function automatic logic [128*15-1:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]       w [60];
    logic [31:0]       t;
    logic [7:0]        rc;
    logic [128*15-1:0] r;
    int                nr;
    nr = nk + 6;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
      r[32*(4*(nr+1)-i)-1 -: 32] = w[i];
    end
    return r;
  endfunction

  // Forward cipher: ciphertext for a given plaintext; the decryptor must invert it.
  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [128*15-1:0] k, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ k[128*(nr+1)-1 -: 128];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      v = v ^ k[128*(nr+1-rnd)-1 -: 128];
    end
    return v;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NK = 4 + 2*g;
    localparam int NR = NK + 6;

    aes_decrypt_core #(.Nk(NK), .Nr(NR), .Nb(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .exp_key   (ek[g][128*(NR+1)-1:0]),
      .in_valid  (iv[g]),
      .in_ready  (irdy[g]),
      .in_data   (idat[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g]),
      .busy      (bsy[g]),
      .dbg_byte  (dbg[g])
    );

    // Monitor: latency on the rising edge of out_valid, data at each handshake, hold while stalled.
    initial begin
      logic         prev_ov, prev_hs;
      logic [127:0] prev_od, want;
      int           st;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
      prev_od = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_ov = 1'b0;
          prev_hs = 1'b0;
        end else begin
          if (ov[g] && !prev_ov) begin
            if (stamp_q[g].size() == 0) fail_now($sformatf("unexpected_out_valid[nk=%0d]", NK));
            else begin
              st = stamp_q[g].pop_front();
              check($sformatf("latency[nk=%0d]", NK), 128'(cyc - st), 128'(NR + 1));
            end
          end
          if (ov[g] && prev_ov && !prev_hs) check($sformatf("hold_data[nk=%0d]", NK), od[g], prev_od);
          if (ov[g]) check($sformatf("in_ready_in_done[nk=%0d]", NK), 128'(irdy[g]), 128'(0));
          if (ov[g] && ordy[g]) begin
            if (exp_q[g].size() == 0) fail_now($sformatf("unexpected_output[nk=%0d]", NK));
            else begin
              want = exp_q[g].pop_front();
              check($sformatf("plaintext[nk=%0d]", NK), od[g], want);
              check($sformatf("dbg_byte[nk=%0d]", NK), 128'(dbg[g]), 128'(want[7:0]));
              check($sformatf("busy_done[nk=%0d]", NK), 128'(bsy[g]), 128'(1));
            end
          end
          prev_ov = ov[g];
          prev_hs = ov[g] && ordy[g];
          prev_od = od[g];
        end
      end
    end
  end

  // Offer one block; returns the cycle index in which the handshake was seen (-1 on timeout).
  task automatic send(input int g, input logic [127:0] ct, input logic [127:0] pt, output int stamp);
    int b;
    b = 0;
    iv[g]   = 1'b1;
    idat[g] = ct;
    @(negedge clk);
    while (!irdy[g] && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!irdy[g]) begin
      fail_now($sformatf("accept_timeout[g=%0d]", g));
      stamp = -1;
      iv[g] = 1'b0;
      return;
    end
    stamp = cyc;
    exp_q[g].push_back(pt);
    stamp_q[g].push_back(cyc);
    @(posedge clk);
    #1 iv[g] = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("drain_pending", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input int g, input string tag);
    check($sformatf("%s_out_valid[g=%0d]", tag, g), 128'(ov[g]),   128'(0));
    check($sformatf("%s_in_ready[g=%0d]", tag, g),  128'(irdy[g]), 128'(1));
    check($sformatf("%s_busy[g=%0d]", tag, g),      128'(bsy[g]),  128'(0));
    check($sformatf("%s_dbg_byte[g=%0d]", tag, g),  128'(dbg[g]),  128'(0));
    check($sformatf("%s_out_data[g=%0d]", tag, g),  od[g],         128'(0));
  endtask

  initial begin
    int           s0, s1, s2, b;
    logic [127:0] pt, pt2;
    logic [255:0] key;
    for (int g = 0; g < 3; g++) begin
      iv[g]   = 1'b0;
      idat[g] = '0;
      ordy[g] = 1'b1;
    end
    build_sbox();
    for (int g = 0; g < 3; g++) ek[g] = expand(FIPS_KEY, 4 + 2*g);

    // Anchor the reference model on the published vectors.
    check("model_aes128", enc(FIPS_PT, ek[0], 10), FIPS_CT0);
    check("model_aes192", enc(FIPS_PT, ek[1], 12), FIPS_CT1);
    check("model_aes256", enc(FIPS_PT, ek[2], 14), FIPS_CT2);

    @(negedge clk);
    for (int g = 0; g < 3; g++) check_reset_outputs(g, "reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Published ciphertexts at each key size.
    send(0, FIPS_CT0, FIPS_PT, s0);
    send(1, FIPS_CT1, FIPS_PT, s0);
    send(2, FIPS_CT2, FIPS_PT, s0);
    drain();

    // Backpressure: result held 20 cycles while a second block waits at the input.
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ordy[1] = 1'b0;
    send(1, FIPS_CT1, FIPS_PT, s0);
    fork
      send(1, enc(pt2, ek[1], 12), pt2, s1);
      begin
        b = 0;
        while (!ov[1] && b < 100) begin
          @(negedge clk);
          b++;
        end
        repeat (20) @(negedge clk);
        check("bp_out_valid_held", 128'(ov[1]), 128'(1));
        check("bp_in_ready_low", 128'(irdy[1]), 128'(0));
        check("bp_out_data_held", od[1], FIPS_PT);
        @(posedge clk);
        #1 ordy[1] = 1'b1;
      end
    join
    drain();

    // Back-to-back stream at full rate.
    send(1, FIPS_CT1, FIPS_PT, s0);
    send(1, FIPS_CT1, FIPS_PT, s1);
    send(1, FIPS_CT1, FIPS_PT, s2);
    check("b2b_spacing_1", 128'(s1 - s0), 128'(14));
    check("b2b_spacing_2", 128'(s2 - s1), 128'(14));
    drain();

    // Reset in the middle of the round loop discards the block.
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(1, enc(pt, ek[1], 12), pt, s0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs(1, "midreset");
    exp_q[1].delete();
    stamp_q[1].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_stale_valid", 128'(ov[1]), 128'(0));
    @(posedge clk);
    #1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(1, enc(pt, ek[1], 12), pt, s0);
    drain();

    // Random keys and plaintexts at every key size.
    for (int g = 0; g < 3; g++) begin
      key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ek[g] = expand(key, 4 + 2*g);
      for (int n = 0; n < 5; n++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(g, enc(pt, ek[g], 10 + 2*g), pt, s0);
      end
      drain();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
